cpu7_ifu: RTL and testbench

Parametrised instruction-fetch unit for the cpu7 pipeline. It replaces the single fetch PC register and next-PC mux with a fetch PC generator, a DEPTH-entry prefetch FIFO and redirect/flush logic. Fetched instructions are held in the FIFO, and in-flight responses are discarded on redirect. Entries are delivered to decode through a valid/ready handshake, with NOP substitution while an interrupt is pending. The block sits between the instruction memory port and the controller/ID-EX pipeline register.

---
 rtl/cpu7_ifu.sv | 148 ++++++++++++++
 tb/tb_cpu7_ifu.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu7_ifu.sv
// cpu7_ifu -- instruction-fetch unit for the cpu7 pipeline.
//
// Generates sequential fetch addresses and prefetches instructions into a
// DEPTH-entry FIFO. Decode takes entries through a valid/ready handshake.
// A redirect (mret, exception flush or taken branch) empties the FIFO,
// discards stale responses and restarts fetching at the new target.
// While an interrupt is pending, the head instruction is shown as NOP_INSTR.
//
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   imem_req_o/imem_addr        fetch request and its 4-byte aligned address
//   imem_rvalid/imem_rdata      response, exactly one cycle after the request
//   mret/mret_pc                redirect to mepc (highest priority)
//   excp_flush/excp_flush_pc    redirect to the trap vector
//   br_taken/br_target          redirect to the EX-stage branch/jump target
//   irq_pending                 forces ifu_instr to NOP_INSTR
//   dec_ready                   decode accepts the head entry
//   ifu_valid/ifu_instr/ifu_pc  head entry presented to decode
//   ifu_fetch_pc                current fetch PC, used for mepc capture
module cpu7_ifu #(
  parameter int              XLEN      = 32,
  parameter int              DEPTH     = 4,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            mret,
  input  logic [XLEN-1:0] mret_pc,
  input  logic            excp_flush,
  input  logic [XLEN-1:0] excp_flush_pc,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_target,
  input  logic            irq_pending,
  input  logic            dec_ready,
  output logic            ifu_valid,
  output logic [XLEN-1:0] ifu_instr,
  output logic [XLEN-1:0] ifu_pc,
  output logic [XLEN-1:0] ifu_fetch_pc
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW+1:0] DEPTH_L = (PW+2)'(DEPTH);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [PW:0]     rd_ptr_q, rd_ptr_d;
  logic [PW:0]     wr_ptr_q, wr_ptr_d;
  logic            inflight_q, inflight_d;
  logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
  logic            kill_q, kill_d;

  logic [XLEN-1:0] pc_mem_q    [DEPTH];
  logic [XLEN-1:0] instr_mem_q [DEPTH];

  logic            redirect;
  logic [XLEN-1:0] target;
  logic [PW:0]     count;
  logic [PW+1:0]   occupancy;
  logic            issue;
  logic            push;
  logic            pop;
  logic            head_valid;

  always_comb begin
    redirect   = mret | excp_flush | br_taken;
    target     = mret ? mret_pc : (excp_flush ? excp_flush_pc : br_target);
    count      = wr_ptr_q - rd_ptr_q;
    head_valid = (count != '0);
    // An outstanding request counts as occupied so its response always has a slot.
    occupancy  = {1'b0, count} + (PW+2)'(inflight_q);
    issue      = !redirect && (occupancy < DEPTH_L);
    push       = imem_rvalid && inflight_q && !kill_q && !redirect;
    pop        = head_valid && dec_ready && !redirect;
  end

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = inflight_q;
    inflight_pc_d = inflight_pc_q;
    kill_d        = kill_q;
    wr_ptr_d      = wr_ptr_q + (PW+1)'(push);
    rd_ptr_d      = rd_ptr_q + (PW+1)'(pop);

    if (issue) begin
      inflight_d    = 1'b1;
      inflight_pc_d = fetch_pc_q;
      fetch_pc_d    = fetch_pc_q + XLEN'(4);
    end else if (imem_rvalid) begin
      inflight_d = 1'b0;
    end

    if (imem_rvalid) begin
      kill_d = 1'b0;
    end

    if (redirect) begin
      rd_ptr_d   = wr_ptr_q;
      fetch_pc_d = {target[XLEN-1:2], 2'b00};
      // A response returning in the redirect cycle is already dropped because
      // the redirect blocks the push, so only a response still to come is killed.
      kill_d     = inflight_q && !imem_rvalid;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      kill_q        <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      kill_q        <= kill_d;
    end
  end

  // FIFO storage needs no reset: the pointers decide which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[wr_ptr_q[PW-1:0]]    <= inflight_pc_q;
      instr_mem_q[wr_ptr_q[PW-1:0]] <= imem_rdata;
    end
  end

  always_comb begin
    imem_req     = issue && !reset;
    imem_addr    = fetch_pc_q;
    ifu_fetch_pc = fetch_pc_q;
    ifu_valid    = head_valid;
    ifu_pc       = head_valid ? pc_mem_q[rd_ptr_q[PW-1:0]] : '0;
    if (irq_pending) begin
      ifu_instr = NOP_INSTR;
    end else begin
      ifu_instr = head_valid ? instr_mem_q[rd_ptr_q[PW-1:0]] : '0;
    end
  end

endmodule

// File: tb/tb_cpu7_ifu.sv
// tb_cpu7_ifu -- self-checking bench for cpu7_ifu.
//
// A queue-based model of the fetch unit predicts every cycle's outputs and a
// negedge process compares them; directed scenarios add literal checks.
module tb_cpu7_ifu;

  localparam int          DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        mret = 1'b0;
  logic [31:0] mret_pc = '0;
  logic        excp_flush = 1'b0;
  logic [31:0] excp_flush_pc = '0;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = '0;
  logic        irq_pending = 1'b0;
  logic        dec_ready = 1'b1;
  logic        ifu_valid;
  logic [31:0] ifu_instr;
  logic [31:0] ifu_pc;
  logic [31:0] ifu_fetch_pc;

  int vectors = 0;
  int miscompares = 0;

  cpu7_ifu #(
    .XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'h0), .NOP_INSTR(NOP)
  ) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .mret(mret), .mret_pc(mret_pc),
    .excp_flush(excp_flush), .excp_flush_pc(excp_flush_pc),
    .br_taken(br_taken), .br_target(br_target),
    .irq_pending(irq_pending), .dec_ready(dec_ready),
    .ifu_valid(ifu_valid), .ifu_instr(ifu_instr),
    .ifu_pc(ifu_pc), .ifu_fetch_pc(ifu_fetch_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instrOf(input logic [31:0] pc);
    return pc ^ 32'hC0DE_0000;
  endfunction

  // Instruction memory: answers every request one cycle later.
  always @(posedge clk) begin
    imem_rvalid <= imem_req;
    imem_rdata  <= instrOf(imem_addr);
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a queue of PCs waiting for decode, the next fetch
  // address, and whether a response is due in the current cycle.
  logic [31:0] mq[$];
  logic [31:0] mFetch = '0;
  logic        mOut = 1'b0;
  logic [31:0] mOutPc = '0;

  function automatic logic modelRedirect();
    return mret | excp_flush | br_taken;
  endfunction

  function automatic logic modelReq();
    return !modelRedirect() && ((mq.size() + int'(mOut)) < DEPTH);
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      mFetch = 32'h0;
      mOut   = 1'b0;
    end else if (modelRedirect()) begin
      mq.delete();
      mFetch = mret ? mret_pc : (excp_flush ? excp_flush_pc : br_target);
      mOut   = 1'b0;
    end else begin
      logic req;
      req = modelReq();
      if (mq.size() > 0 && dec_ready) void'(mq.pop_front());
      if (mOut) mq.push_back(mOutPc);
      if (req) begin
        mOutPc = mFetch;
        mFetch = mFetch + 32'd4;
        mOut   = 1'b1;
      end else begin
        mOut = 1'b0;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (!reset) begin
      logic expReq;
      expReq = modelReq();
      checkOutput("imem_req", {31'b0, imem_req}, {31'b0, expReq});
      if (expReq) checkOutput("imem_addr", imem_addr, mFetch);
      checkOutput("ifu_fetch_pc", ifu_fetch_pc, mFetch);
      checkOutput("ifu_valid", {31'b0, ifu_valid}, {31'b0, mq.size() > 0});
      if (mq.size() > 0) begin
        checkOutput("ifu_pc", ifu_pc, mq[0]);
        checkOutput("ifu_instr", ifu_instr, irq_pending ? NOP : instrOf(mq[0]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic m, input logic e, input logic b, input logic [31:0] tgt);
    mret = m;
    excp_flush = e;
    br_taken = b;
    mret_pc = 32'h200;
    excp_flush_pc = 32'h80;
    br_target = tgt;
  endtask

  task automatic freshReset(input logic rdy);
    reset = 1'b1;
    dec_ready = rdy;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int nReq;
    logic [31:0] seen [4];

    // Reset values while held in reset.
    tick();
    tick();
    #1;
    checkOutput("rst imem_req", {31'b0, imem_req}, 32'd0);
    checkOutput("rst imem_addr", imem_addr, 32'h0);
    checkOutput("rst ifu_valid", {31'b0, ifu_valid}, 32'd0);
    checkOutput("rst ifu_instr", ifu_instr, 32'h0);
    checkOutput("rst ifu_pc", ifu_pc, 32'h0);

    // Reset release, streaming.
    tick();
    reset = 1'b0;
    #1;
    checkOutput("c0 imem_req", {31'b0, imem_req}, 32'd1);
    checkOutput("c0 imem_addr", imem_addr, 32'h0);
    tick();
    checkOutput("c1 imem_addr", imem_addr, 32'h4);
    tick();
    checkOutput("c2 ifu_valid", {31'b0, ifu_valid}, 32'd1);
    checkOutput("c2 ifu_pc", ifu_pc, 32'h0);
    tick();
    checkOutput("c3 ifu_pc", ifu_pc, 32'h4);
    repeat (6) tick();

    // Backpressure: exactly DEPTH requests, then ordered drain.
    freshReset(1'b0);
    nReq = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (imem_req) nReq++;
      tick();
    end
    checkOutput("bp requests", nReq, 4);
    dec_ready = 1'b1;
    #1;
    checkOutput("bp head pc", ifu_pc, 32'h0);
    checkOutput("bp req held", {31'b0, imem_req}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      seen[k] = ifu_pc;
      if (k == 0) begin
        checkOutput("bp refetch req", {31'b0, imem_req}, 32'd1);
        checkOutput("bp refetch addr", imem_addr, 32'h10);
      end
    end
    checkOutput("bp pc1", seen[0], 32'h4);
    checkOutput("bp pc2", seen[1], 32'h8);
    checkOutput("bp pc3", seen[2], 32'hC);
    checkOutput("bp pc4", seen[3], 32'h10);

    // Branch with 3 queued and a response in flight.
    freshReset(1'b0);
    repeat (4) tick();
    checkOutput("br queued head", ifu_pc, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h100);
    #1;
    checkOutput("br no req", {31'b0, imem_req}, 32'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    dec_ready = 1'b1;
    #1;
    checkOutput("br N+1 valid", {31'b0, ifu_valid}, 32'd0);
    checkOutput("br N+1 addr", imem_addr, 32'h100);
    tick();
    tick();
    checkOutput("br N+3 pc", ifu_pc, 32'h100);
    tick();
    checkOutput("br N+4 pc", ifu_pc, 32'h104);

    // Redirect priority.
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h40);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    tick();
    checkOutput("prio mret pc", ifu_pc, 32'h200);
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h40);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    tick();
    checkOutput("prio excp pc", ifu_pc, 32'h80);

    // Interrupt NOP substitution.
    irq_pending = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h24);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    tick();
    checkOutput("irq instr", ifu_instr, 32'h13);
    checkOutput("irq pc", ifu_pc, 32'h24);
    tick();
    checkOutput("irq popped pc", ifu_pc, 32'h28);
    irq_pending = 1'b0;
    #1;
    checkOutput("irq cleared instr", ifu_instr, 32'hC0DE_0028);

    // Fetch PC wrap.
    applyStimulus(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    #1;
    checkOutput("wrap addr hi", imem_addr, 32'hFFFF_FFFC);
    tick();
    checkOutput("wrap addr 0", imem_addr, 32'h0);

    // Reset with FIFO full.
    dec_ready = 1'b0;
    repeat (8) tick();
    checkOutput("full valid", {31'b0, ifu_valid}, 32'd1);
    checkOutput("full no req", {31'b0, imem_req}, 32'd0);
    reset = 1'b1;
    #1;
    checkOutput("full rst valid", {31'b0, ifu_valid}, 32'd0);
    tick();
    reset = 1'b0;
    dec_ready = 1'b1;
    #1;
    checkOutput("full rst req", {31'b0, imem_req}, 32'd1);
    checkOutput("full rst addr", imem_addr, 32'h0);

    // Short reset pulse while a response is arriving: it must be ignored.
    repeat (5) tick();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    checkOutput("pulse valid", {31'b0, ifu_valid}, 32'd0);
    tick();
    checkOutput("pulse stale dropped", {31'b0, ifu_valid}, 32'd0);
    tick();
    checkOutput("pulse first pc", ifu_pc, 32'h0);
    repeat (4) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
